// File: rtl/seg7_scan_display_if.sv
// Byte stream from the UART RX stage into the 7-segment scanner.
// The master drives the byte and its ready level; the slave samples them.
interface seg7_scan_display_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );
endinterface

// File: rtl/seg7_scan_display.sv
// ASCII byte stream to scrolling digit buffer, shown on a multiplexed
// common 7-segment display with a registered segment/enable pipeline.
module seg7_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 30000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seg7_scan_display_if.slave      rxIf,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [3:0] CODE_DASH  = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           scanIdx;
    logic                    rxValidD;
    logic [4*NUM_DIGITS-1:0] digitBuf;
    logic [4*NUM_DIGITS-1:0] bufNext;

    logic                    accept;
    logic                    isDigit;
    logic                    isDash;
    logic                    isClear;
    logic                    scanTick;
    logic [3:0]              curCode;
    logic [NUM_DIGITS-1:0]   oneHot;

    function automatic logic [6:0] encodeSeg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hE:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Edge-detect the level-style ready so a held byte is taken once.
    assign accept = rxIf.rx_valid & ~rxValidD;

    assign isDigit = (rxIf.rx_data >= 8'h30) &&
                     (rxIf.rx_data <= 8'h39);
    assign isDash  = (rxIf.rx_data == 8'h2D);
    assign isClear = (rxIf.rx_data == 8'h43) ||
                     (rxIf.rx_data == 8'h63);

    assign scanTick = (prescaler == PW'(SCAN_DIV - 1));

    always_comb begin
        bufNext = digitBuf;
        if (accept) begin
            unique case (1'b1)
                isDigit, isDash: begin
                    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
                        bufNext[4*k +: 4] = digitBuf[4*(k-1) +: 4];
                    end
                    bufNext[3:0] = isDigit ? rxIf.rx_data[3:0]
                                           : CODE_DASH;
                end
                isClear: begin
                    bufNext = {NUM_DIGITS{CODE_BLANK}};
                end
                default: begin
                    bufNext = digitBuf;
                end
            endcase
        end
    end

    always_comb begin
        curCode = CODE_BLANK;
        oneHot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scanIdx == IW'(k)) begin
                curCode   = digitBuf[4*k +: 4];
                oneHot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxValidD <= 1'b0;
            digitBuf <= {NUM_DIGITS{CODE_BLANK}};
        end else begin
            rxValidD <= rxIf.rx_valid;
            digitBuf <= bufNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            scanIdx   <= '0;
        end else if (scanTick) begin
            prescaler <= '0;
            if (scanIdx == IW'(NUM_DIGITS - 1)) begin
                scanIdx <= '0;
            end else begin
                scanIdx <= scanIdx + IW'(1);
            end
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Segments and enables come from the same index in the same register
    // stage, so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg    <= 7'h00;
            dig_en <= NUM_DIGITS'(1);
        end else begin
            seg    <= encodeSeg(curCode);
            dig_en <= oneHot;
        end
    end

    assign digits = digitBuf;

endmodule
